// File: rtl/demux16_pkg.sv
// Shared constants and types for the 1:16 TDM receive demultiplexer.
package demux16_pkg;

    localparam int unsigned NUM_SLOTS = 16;
    localparam int unsigned SEL_W     = 4;

    localparam logic [NUM_SLOTS-1:0] OUT_RST = '0;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/demux16_slot_ctr.sv
// Slot counter: tracks the index of the next expected bit within a frame.
module demux16_slot_ctr
    import demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load1,
    input  logic             inc,
    input  logic             clr,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    // clr wins over load1, load1 wins over inc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clr) begin
            sel <= '0;
        end else if (load1) begin
            sel <= SEL_W'(1);
        end else if (inc) begin
            sel <= sel + 1'b1;
        end
    end

    assign last = (sel == SEL_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/demux16_tdm_rx.sv
// Serial-to-parallel 1:16 TDM demultiplexer, framed by Sync and qualified by En.
module demux16_tdm_rx
    import demux16_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Din,
    input  logic                 En,
    input  logic                 Sync,
    output logic [NUM_SLOTS-1:0] Out,
    output logic                 Valid,
    output logic [SEL_W-1:0]     Sel,
    output logic                 Err
);

    state_t state, state_nxt;

    // Slot 15 goes straight to Out, so the shadow only holds slots 0..14.
    logic [NUM_SLOTS-2:0] shadow, shadow_nxt;
    logic [NUM_SLOTS-1:0] out_nxt;
    logic                 valid_nxt, err_nxt;
    logic                 ctr_load1, ctr_inc, ctr_clr;
    logic                 last;

    demux16_slot_ctr u_slot_ctr (
        .clk   (Clk),
        .rst_n (Rst_n),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .clr   (ctr_clr),
        .sel   (Sel),
        .last  (last)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        out_nxt    = Out;
        valid_nxt  = 1'b0;
        err_nxt    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_inc    = 1'b0;
        ctr_clr    = 1'b0;

        if (En) begin
            unique case (state)
                IDLE: begin
                    if (Sync) begin
                        shadow_nxt = {{(NUM_SLOTS-2){1'b0}}, Din};
                        ctr_load1  = 1'b1;
                        state_nxt  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (Sync) begin
                        // Early resync: drop the partial frame, this bit is slot 0.
                        err_nxt    = 1'b1;
                        shadow_nxt = {{(NUM_SLOTS-2){1'b0}}, Din};
                        ctr_load1  = 1'b1;
                    end else if (last) begin
                        out_nxt   = {Din, shadow};
                        valid_nxt = 1'b1;
                        ctr_clr   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        for (int unsigned k = 0; k < NUM_SLOTS - 1; k++) begin
                            if (Sel == SEL_W'(k)) begin
                                shadow_nxt[k] = Din;
                            end
                        end
                        ctr_inc = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shadow <= '0;
            Out    <= OUT_RST;
            Valid  <= 1'b0;
            Err    <= 1'b0;
        end else begin
            shadow <= shadow_nxt;
            Out    <= out_nxt;
            Valid  <= valid_nxt;
            Err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_demux16_tdm_rx.sv
// Self-checking bench for demux16_tdm_rx: vector table, directed frames and random traffic.
module tb_demux16_tdm_rx;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Din;
    logic        En;
    logic        Sync;
    logic [15:0] Out;
    logic        Valid;
    logic [3:0]  Sel;
    logic        Err;

    demux16_tdm_rx dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Din   (Din),
        .En    (En),
        .Sync  (Sync),
        .Out   (Out),
        .Valid (Valid),
        .Sel   (Sel),
        .Err   (Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = 0;
    int sync_cyc = 0;
    bit track_phase = 1'b0;

    // Reference model: bits of the frame in progress; empty means no frame open.
    logic        bq[$];
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_err;

    typedef struct {
        logic        en;
        logic        sync;
        logic        din;
        logic [15:0] out;
        logic        valid;
        logic        err;
        logic [3:0]  sel;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        m_out   = 16'h0000;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic sync, input logic din);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (en) begin
            if (sync) begin
                if (bq.size() > 0) m_err = 1'b1;
                bq.delete();
                bq.push_back(din);
            end else if (bq.size() > 0) begin
                bq.push_back(din);
                if (bq.size() == 16) begin
                    for (int k = 0; k < 16; k++) m_out[k] = bq[k];
                    m_valid = 1'b1;
                    bq.delete();
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic sync, input logic din);
        logic [3:0] exp_sel;
        En   = en;
        Sync = sync;
        Din  = din;
        @(posedge Clk);
        cyc++;
        model_edge(en, sync, din);
        #1;
        exp_sel = 4'(bq.size() % 16);
        chk("out", Out, m_out);
        chk("valid", 16'(Valid), 16'(m_valid));
        chk("err", 16'(Err), 16'(m_err));
        chk("sel", 16'(Sel), 16'(exp_sel));
        if (Valid && Err) chk("valid_err_excl", 16'(Valid & Err), 16'h0000);
        if (Valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (track_phase) chk("walk_valid_edge", 16'((cyc - sync_cyc + 1) % 16), 16'h0000);
        end
        if (Err) n_err++;
    endtask

    task automatic send_frame(input logic [15:0] w, input logic [15:0] gap_after);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, w[k]);
            if (gap_after[k]) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    // Called just after a posedge; asserts reset between edges and checks it took effect at once.
    task automatic do_reset();
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_out", Out, 16'h0000);
        chk("rst_async_sel", 16'(Sel), 16'h0000);
        chk("rst_async_valid", 16'(Valid), 16'h0000);
        chk("rst_async_err", 16'(Err), 16'h0000);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        int v0, e0;
        logic [15:0] w;

        Rst_n = 1'b0;
        En    = 1'b0;
        Sync  = 1'b0;
        Din   = 1'b0;
        model_reset();
        #1;
        chk("init_rst_out", Out, 16'h0000);
        chk("init_rst_sel", 16'(Sel), 16'h0000);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 4'd0});
        w = 16'hBEEF;
        for (int k = 0; k < 16; k++)
            tbl.push_back('{1'b1, k == 0, w[k], (k == 15) ? 16'hBEEF : 16'h0000, k == 15, 1'b0, 4'((k + 1) % 16)});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 4'd1});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 4'd2});
        tbl.push_back('{1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 4'd3});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b1, 4'd1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 4'd1});
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].sync, tbl[i].din);
            chk("tbl_out", Out, tbl[i].out);
            chk("tbl_valid", 16'(Valid), 16'(tbl[i].valid));
            chk("tbl_err", 16'(Err), 16'(tbl[i].err));
            chk("tbl_sel", 16'(Sel), 16'(tbl[i].sel));
        end
        do_reset();

        // One-hot walk, back-to-back frames
        v0 = n_valid;
        sync_cyc = cyc + 1;
        track_phase = 1'b1;
        for (int f = 0; f < 16; f++) send_frame(16'(1 << f), 16'h0000);
        track_phase = 1'b0;
        chk("walk_valid_count", 16'(n_valid - v0), 16'd16);
        chk("walk_last_out", Out, 16'h8000);

        // Gapped frame, En=0 after slots 3 and 9
        sync_cyc = cyc + 1;
        send_frame(16'hA5C3, 16'h0208);
        chk("gap_out", Out, 16'hA5C3);
        chk("gap_latency", 16'(last_valid_cyc - sync_cyc), 16'd17);

        // No sync: 40 bits with En=1, Sync=0
        v0 = n_valid;
        e0 = n_err;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'($urandom));
        chk("nosync_valid", 16'(n_valid - v0), 16'd0);
        chk("nosync_err", 16'(n_err - e0), 16'd0);
        chk("nosync_out", Out, 16'hA5C3);

        // Early resync
        v0 = n_valid;
        e0 = n_err;
        for (int k = 0; k < 7; k++) step(1'b1, k == 0, 1'b1);
        send_frame(16'h1234, 16'h0000);
        chk("resync_err_count", 16'(n_err - e0), 16'd1);
        chk("resync_valid_count", 16'(n_valid - v0), 16'd1);
        chk("resync_out", Out, 16'h1234);

        // Reset mid-frame
        send_frame(16'h1357, 16'h0000);
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, 1'b1);
        do_reset();
        send_frame(16'h00FF, 16'h0000);
        chk("rstmid_out", Out, 16'h00FF);

        // Random traffic
        v0 = n_valid;
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, 1'($urandom));
        if (n_valid == v0) chk("rand_some_frames", 16'(n_valid - v0), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
